fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues PCs to a synchronous-read ROM and buffers the returned
// words with their PCs in a small FIFO, using credit-based issue so the FIFO can never overflow.
module fetch_queue #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INST_W-1:0]            imem_data,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_addr,
    output logic                         inst_valid,
    output logic [INST_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              enq;
    logic              pop;

    // Credit counts the in-flight read but deliberately ignores a same-cycle pop.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
        issue     = !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
        enq       = pending_q && !redirect;
        pop       = inst_valid && inst_ready && !redirect;
    end

    always_comb begin
        pc_d      = pc_q;
        pending_d = 1'b0;
        pend_pc_d = pend_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (redirect) begin
            pc_d     = redirect_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d      = pc_q + ADDR_W'(1);
                pending_d = 1'b1;
                pend_pc_d = pc_q;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            pending_q <= 1'b0;
            pend_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
            pend_pc_q <= pend_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            inst_mem_q[wr_ptr_q] <= imem_data;
            pc_mem_q[wr_ptr_q]   <= pend_pc_q;
        end
    end

    assign imem_addr  = pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked against a
// queue-of-PCs reference model of the fetch pipeline and an in-order acceptance scoreboard.
module tb_fetch_queue;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INST_W = 16;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic [2:0]        count;

    fetch_queue #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM, ROM[i] = i + 0x100.
    always @(posedge clk) imem_data <= 16'h0100 + 16'(imem_addr);

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: fetch PC, one in-flight read, and a queue of fetched PCs.
    logic [ADDR_W-1:0] m_pc;
    bit                m_inf;
    logic [ADDR_W-1:0] m_inf_pc;
    logic [ADDR_W-1:0] m_q[$];

    logic [ADDR_W-1:0] exp_next;
    logic [ADDR_W-1:0] acc_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_step();
        int occ;
        bit iss;
        if (rst) begin
            m_pc  = '0;
            m_inf = 1'b0;
            m_q.delete();
        end else if (redirect) begin
            m_pc  = redirect_addr;
            m_inf = 1'b0;
            m_q.delete();
        end else begin
            occ = m_q.size() + int'(m_inf);
            iss = occ < int'(DEPTH);
            if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_pc);
            if (iss) begin
                m_inf    = 1'b1;
                m_inf_pc = m_pc;
                m_pc     = m_pc + 8'd1;
            end else begin
                m_inf = 1'b0;
            end
        end
    endtask

    task automatic tick();
        bit                acc;
        logic [ADDR_W-1:0] acc_pc;
        acc    = (inst_valid === 1'b1) && inst_ready && !redirect && !rst;
        acc_pc = inst_pc;
        @(posedge clk);
        model_step();
        if (acc) begin
            check("accept_order", 32'(acc_pc), 32'(exp_next));
            exp_next = acc_pc + 8'd1;
            acc_log.push_back(acc_pc);
        end
        if (rst) exp_next = '0;
        else if (redirect) exp_next = redirect_addr;
        #1;
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("count", 32'(count), 32'(m_q.size()));
        check("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
        check("count_bound", 32'(int'(count) <= int'(DEPTH)), 32'd1);
        if (m_q.size() != 0) begin
            check("inst_pc", 32'(inst_pc), 32'(m_q[0]));
            check("inst", 32'(inst), 32'(16'h0100 + 16'(m_q[0])));
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (acc_log.size() > i) ? 32'(acc_log[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [ADDR_W-1:0] wrap_exp[4];
        wrap_exp[0] = 8'hFE;
        wrap_exp[1] = 8'hFF;
        wrap_exp[2] = 8'h00;
        wrap_exp[3] = 8'h01;
        m_pc          = '0;
        m_inf         = 1'b0;
        exp_next      = '0;
        rst           = 1'b1;
        redirect      = 1'b0;
        redirect_addr = '0;
        inst_ready    = 1'b1;
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // Boot stream: first word two cycles after release, then one per cycle.
        rst = 1'b0;
        tick();
        check("boot_c1_valid", 32'(inst_valid), 32'd0);
        tick();
        check("boot_c2_valid", 32'(inst_valid), 32'd1);
        check("boot_inst0", 32'(inst), 32'h100);
        check("boot_pc0", 32'(inst_pc), 32'h0);
        tick();
        check("boot_inst1", 32'(inst), 32'h101);
        check("boot_pc1", 32'(inst_pc), 32'h1);
        tick();
        check("boot_inst2", 32'(inst), 32'h102);
        check("boot_pc2", 32'(inst_pc), 32'h2);

        // Stall: queue saturates, then drains in order without gaps.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        inst_ready = 1'b0;
        repeat (10) tick();
        check("stall_count", 32'(count), 32'd4);
        check("stall_addr", 32'(imem_addr), 32'd4);
        acc_log.delete();
        inst_ready = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 5; i++) check("drain_order", log_at(i), 32'(i));

        // Redirect while three words are queued.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && count != 3'd3; i++) tick();
        check("fill3", 32'(count), 32'd3);
        inst_ready    = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'h40;
        tick();
        redirect = 1'b0;
        check("redir_n1_count", 32'(count), 32'd0);
        check("redir_n1_valid", 32'(inst_valid), 32'd0);
        check("redir_n1_addr", 32'(imem_addr), 32'h40);
        tick();
        check("redir_n2_valid", 32'(inst_valid), 32'd0);
        tick();
        check("redir_n3_valid", 32'(inst_valid), 32'd1);
        check("redir_n3_pc", 32'(inst_pc), 32'h40);

        // PC wrap across 0xFF.
        redirect      = 1'b1;
        redirect_addr = 8'hFE;
        tick();
        redirect = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 20 && acc_log.size() < 4; i++) tick();
        for (int i = 0; i < 4; i++) check("wrap_pc", log_at(i), 32'(wrap_exp[i]));

        // Back-to-back redirects: only the last target is fetched.
        redirect      = 1'b1;
        redirect_addr = 8'h10;
        tick();
        redirect_addr = 8'h20;
        tick();
        redirect = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 20 && acc_log.size() < 1; i++) tick();
        check("b2b_first_pc", log_at(0), 32'h20);

        // Reset pulse with two queued words and a read in flight.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        inst_ready = 1'b0;
        repeat (3) tick();
        check("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            redirect      = ($urandom_range(0, 29) == 0);
            redirect_addr = 8'($urandom);
            inst_ready    = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst      = 1'b0;
        redirect = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
